// File: rtl/ysyx_22051145_scoreboard.sv
// Issue-control scoreboard between decode and execute.
// It tracks pending writes from long-latency ops (loads, mul/div) and blocks
// issue on RAW/WAW hazards against them. After a flush it holds issue off
// until every tracked op has written back. Only the valid/ready handshake is
// gated; no datapath passes through this block.
module ysyx_22051145_scoreboard #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  output logic             id_ready_o,
  input  logic [4:0]       rs1_raddr_i,
  input  logic [4:0]       rs2_raddr_i,
  input  logic             access_rd_i,
  input  logic [4:0]       rd_waddr_i,
  input  logic             long_op_i,
  input  logic             ex_ready_i,
  output logic             issue_valid_o,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_waddr_i,
  input  logic             flush_i,
  output logic [31:0]      busy_mask_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             stall_o
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hazard;
  logic full;
  logic fire;
  logic tracked;
  logic wb_hit;

  // Hazard detection, issue gating and handshake; mask is the registered copy only
  always_comb begin
    hazard = ((rs1_raddr_i != 5'd0) && mask_q[rs1_raddr_i]) ||
             ((rs2_raddr_i != 5'd0) && mask_q[rs2_raddr_i]) ||
             (access_rd_i && (rd_waddr_i != 5'd0) && mask_q[rd_waddr_i]);
    full   = long_op_i && (cnt_q == CNT_W'(MAX_OUT));
    issue_valid_o = id_valid_i && rst_n && (state_q == RUN) && !flush_i &&
                    !hazard && !full;
    id_ready_o = issue_valid_o && ex_ready_i;
    stall_o    = id_valid_i && !id_ready_o;
    fire       = id_ready_o;
    tracked    = fire && long_op_i && access_rd_i && (rd_waddr_i != 5'd0);
    wb_hit     = wb_valid_i && (wb_waddr_i != 5'd0) && mask_q[wb_waddr_i];
  end

  // Next-state for mask, outstanding counter and RUN/DRAIN control
  always_comb begin
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    state_d = state_q;

    if (wb_hit) begin
      mask_d[wb_waddr_i] = 1'b0;
    end
    if (tracked) begin
      mask_d[rd_waddr_i] = 1'b1;
    end
    mask_d[0] = 1'b0;

    case ({tracked, wb_hit})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (flush_i) begin
      state_d = DRAIN;
    end else if ((state_q == DRAIN) && (cnt_q == '0)) begin
      state_d = RUN;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_mask_o   = mask_q;
  assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_ysyx_22051145_scoreboard.sv
// Directed testbench for the issue scoreboard with hand-computed expectations.
module tb_ysyx_22051145_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [4:0]  rs1_raddr_i;
  logic [4:0]  rs2_raddr_i;
  logic        access_rd_i;
  logic [4:0]  rd_waddr_i;
  logic        long_op_i;
  logic        ex_ready_i;
  logic        issue_valid_o;
  logic        wb_valid_i;
  logic [4:0]  wb_waddr_i;
  logic        flush_i;
  logic [31:0] busy_mask_o;
  logic [2:0]  outstanding_o;
  logic        stall_o;

  int checks;
  int failures;

  ysyx_22051145_scoreboard #(.MAX_OUT(4), .CNT_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid_i),
    .id_ready_o    (id_ready_o),
    .rs1_raddr_i   (rs1_raddr_i),
    .rs2_raddr_i   (rs2_raddr_i),
    .access_rd_i   (access_rd_i),
    .rd_waddr_i    (rd_waddr_i),
    .long_op_i     (long_op_i),
    .ex_ready_i    (ex_ready_i),
    .issue_valid_o (issue_valid_o),
    .wb_valid_i    (wb_valid_i),
    .wb_waddr_i    (wb_waddr_i),
    .flush_i       (flush_i),
    .busy_mask_o   (busy_mask_o),
    .outstanding_o (outstanding_o),
    .stall_o       (stall_o)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic acc, input logic [4:0] rd, input logic lng,
                               input logic exr, input logic wbv, input logic [4:0] wba,
                               input logic fl);
    id_valid_i  = v;
    rs1_raddr_i = rs1;
    rs2_raddr_i = rs2;
    access_rd_i = acc;
    rd_waddr_i  = rd;
    long_op_i   = lng;
    ex_ready_i  = exr;
    wb_valid_i  = wbv;
    wb_waddr_i  = wba;
    flush_i     = fl;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic wbOnly(input logic [4:0] a);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, a, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectReady(input string tag, input logic exp_ready);
    checkOutput({tag, "_ready"}, {31'd0, id_ready_o}, {31'd0, exp_ready});
    checkOutput({tag, "_stall"}, {31'd0, stall_o}, {31'd0, id_valid_i & ~exp_ready});
  endtask

  task automatic expectState(input string tag, input logic [31:0] mask, input logic [2:0] cnt);
    checkOutput({tag, "_mask"}, busy_mask_o, mask);
    checkOutput({tag, "_cnt"}, {29'd0, outstanding_o}, {29'd0, cnt});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    @(negedge clk);

    // Reset holds handshake low even with a valid ALU op present
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("rst_issue_valid", {31'd0, issue_valid_o}, 32'd0);
    checkOutput("rst_ready", {31'd0, id_ready_o}, 32'd0);
    step();
    step();
    expectState("rst", 32'h0, 3'd0);
    rst_n = 1'b1;

    // add x3,x1,x2 issues the same cycle
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("add", 1'b1);
    step();
    expectState("add", 32'h0, 3'd0);

    // lw x5 tracked
    applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("lw5", 1'b1);
    step();
    expectState("lw5", 32'h20, 3'd1);

    // add x6,x5,x1 stalls on RAW; writeback does not bypass
    applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("raw", 1'b0);
    step();
    applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    expectReady("raw_wb_same", 1'b0);
    step();
    expectState("raw_wb", 32'h0, 3'd0);
    applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("raw_release", 1'b1);
    step();

    // WAW: lw x7 then mul x7
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("lw7", 1'b1);
    step();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("waw", 1'b0);
    step();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
    expectReady("waw_wb_same", 1'b0);
    step();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("waw_release", 1'b1);
    step();
    expectState("mul7", 32'h80, 3'd1);
    wbOnly(5'd7);
    step();
    expectState("mul7_wb", 32'h0, 3'd0);

    // Load to x0 is not tracked; stray writebacks are ignored
    applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("lw0", 1'b1);
    step();
    expectState("lw0", 32'h0, 3'd0);
    wbOnly(5'd9);
    step();
    expectState("wb_clear_bit", 32'h0, 3'd0);
    wbOnly(5'd0);
    step();
    expectState("wb_x0", 32'h0, 3'd0);

    // ex_ready low: valid offered but not accepted, no state change
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("exr0_issue_valid", {31'd0, issue_valid_o}, 32'd1);
    expectReady("exr0", 1'b0);
    step();
    expectState("exr0", 32'h0, 3'd0);

    // Fill to MAX_OUT with loads to x1..x4
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'(i), 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
      expectReady("fill", 1'b1);
      step();
    end
    expectState("full", 32'h1E, 3'd4);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("lw8_full", 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("alu9_full", 1'b1);
    step();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
    expectReady("lw8_wb_same", 1'b0);
    step();
    expectState("after_wb2", 32'h1A, 3'd3);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("lw8_go", 1'b1);
    step();
    expectState("lw8", 32'h11A, 3'd4);
    wbOnly(5'd1);  step();
    wbOnly(5'd3);  step();
    wbOnly(5'd4);  step();
    wbOnly(5'd8);  step();
    expectState("drained", 32'h0, 3'd0);

    // Flush with two loads pending
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd13, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    expectState("two_pending", 32'h3000, 3'd2);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd20, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    expectReady("flush_cycle", 1'b0);
    step();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd20, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("drain1", 1'b0);
    step();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd20, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0);
    expectReady("drain_wb12", 1'b0);
    step();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd20, 1'b0, 1'b1, 1'b1, 5'd13, 1'b0);
    expectReady("drain_wb13", 1'b0);
    step();
    expectState("drain_empty", 32'h0, 3'd0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd20, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("drain_last", 1'b0);
    step();
    expectReady("resume", 1'b1);
    step();

    // Flush with nothing outstanding blocks exactly one extra cycle
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd21, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    expectReady("flush0", 1'b0);
    step();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd21, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("flush0_drain", 1'b0);
    step();
    expectReady("flush0_run", 1'b1);
    step();

    // Simultaneous tracked issue to x10 and writeback of x11
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd11, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    expectState("lw11", 32'h800, 3'd1);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd10, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0);
    expectReady("lw10_wb11", 1'b1);
    step();
    expectState("swap", 32'h400, 3'd1);

    // Reset dominates a same-cycle writeback and flush
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd15, 1'b1, 1'b1, 1'b1, 5'd10, 1'b1);
    checkOutput("midrst_ready", {31'd0, id_ready_o}, 32'd0);
    step();
    expectState("midrst", 32'h0, 3'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    expectReady("post_rst_run", 1'b1);
    step();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22051145_scoreboard.md
Name: ysyx_22051145_scoreboard

Overview:
Issue-control scoreboard between the decode stage and the execute stage. It uses the decoder's register addresses (rs1/rs2/rd) and long-latency class (load, mul/div) to block issue on RAW/WAW hazards against in-flight long ops. It tracks outstanding long ops and drains the pipeline after a flush. It holds no datapath; it only gates the valid/ready handshake.

Parameters:
MAX_OUT, 4, max simultaneously outstanding tracked long ops (1..15)
CNT_W, 3, width of outstanding counter, must hold 0..MAX_OUT

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
id_valid_i  input  1  decode holds a valid instruction
id_ready_o  output  1  scoreboard accepts instruction this cycle
rs1_raddr_i  input  5  decoded rs1 address (0 when unused)
rs2_raddr_i  input  5  decoded rs2 address (0 when unused)
access_rd_i  input  1  instruction writes rd
rd_waddr_i  input  5  decoded rd address
long_op_i  input  1  instruction is load or mul/div (late writeback)
ex_ready_i  input  1  execute stage can accept
issue_valid_o  output  1  valid toward execute stage
wb_valid_i  input  1  long-op writeback completes this cycle
wb_waddr_i  input  5  writeback destination
flush_i  input  1  pipeline flush (branch/trap/mret)
busy_mask_o  output  32  registered pending-write mask, bit0 always 0
outstanding_o  output  CNT_W  registered count of tracked long ops
stall_o  output  1  id_valid_i & ~id_ready_o

Behaviour:
- Reset (rst_n=0 at edge): busy_mask_o=0, outstanding_o=0, state=RUN. While rst_n=0, id_ready_o=0 and issue_valid_o=0.
- States: RUN (issue allowed), DRAIN (issue blocked).
- hazard = (rs1!=0 & mask[rs1]) | (rs2!=0 & mask[rs2]) | (access_rd & rd!=0 & mask[rd]). Evaluated against the registered mask only; a writeback releases the stall from the next cycle (no same-cycle bypass).
- full = long_op_i & (outstanding_o == MAX_OUT).
- issue_valid_o = id_valid_i & state==RUN & ~flush_i & ~hazard & ~full. Combinational; no added latency.
- id_ready_o = issue_valid_o & ex_ready_i. fire = id_ready_o.
- tracked = fire & long_op_i & access_rd_i & rd_waddr_i!=0. Sets mask[rd] and increments the counter.
- Non-tracked ops never touch state. This includes long_op with rd=x0 and stores.
- Writeback: if wb_valid_i and mask[wb_waddr] is set, clear the bit and decrement the counter. A writeback to a clear bit or to x0 is ignored; the counter never underflows.
- Simultaneous tracked issue and valid writeback (necessarily different regs, since WAW blocks the same rd): set one bit, clear the other, counter unchanged.
- Flush: flush_i=1 in any state forces state to DRAIN next cycle and blocks issue in the same cycle. Flush has priority over fire.
- Mask/counter keep updating from writebacks in DRAIN; in-flight ops still complete.
- DRAIN->RUN when outstanding_o==0 and flush_i=0, evaluated at the edge. Minimum one blocked cycle after any flush, even with counter 0.
- Flush during DRAIN: stay in DRAIN.
- Reset mid-operation: reset dominates everything, including a same-cycle writeback or flush.
- Counter saturates by construction: full blocks the increment at MAX_OUT.

Test Plan:
- Reset then issue `add x3,x1,x2` (long_op=0, ex_ready=1) -> id_ready_o=1 in the same cycle; mask=0, outstanding=0.
- Issue lw x5 (tracked), next cycle add x6,x5,x1 -> busy_mask_o=0x20, outstanding=1, stall_o=1. wb_valid x5 at cycle N -> mask=0 at N+1, add issues at N+1, not N.
- WAW: lw x7 pending, then mul x7,... -> stalled until x7 writeback. Load to x0 -> issues, mask stays 0, outstanding stays 0.
- Four tracked loads to x1..x4 (MAX_OUT=4) -> outstanding=4. Fifth load to x8 stalls while an ALU op to x9 still issues. wb x2 -> fifth load issues one cycle later, outstanding returns to 4.
- Two tracked loads pending, flush_i pulse with id_valid high -> id_ready_o=0 that cycle, state DRAIN, issue blocked through both writebacks. RUN resumes the cycle after outstanding reaches 0. Flush with outstanding=0 -> exactly one blocked cycle.
- Same-cycle tracked issue to x10 and wb to x11 (pending) -> mask bit10 set, bit11 cleared, outstanding unchanged. rst_n=0 while ops pending -> mask=0, outstanding=0, RUN.
